// File: rtl/mc_move_selector.sv
`default_nettype none
// ============================================================================
// Module   : mc_move_selector
// Brief    : Sweeps the Monte Carlo statistics engine over the four candidate
//            first moves, scores each by its accumulated move total and
//            reports the best direction.
// Revision : 1.0 - initial release
// ============================================================================
module mc_move_selector #(
  parameter int unsigned TRIALS          = 256,
  parameter int unsigned TIMEOUT         = 32'd16777216,
  parameter int unsigned STAT_RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] board_in,
  input  logic [7:0]  seed_in,
  input  logic [2:0]  prob_in,
  output logic        busy,
  output logic        done,
  output logic [1:0]  best_dir,
  output logic [31:0] best_score,
  output logic [15:0] best_max,
  output logic [3:0]  timeout_mask,
  output logic        stat_rst,
  output logic [1:0]  stat_restrected,
  output logic [2:0]  stat_restrect_prob,
  output logic [79:0] stat_board,
  output logic [7:0]  stat_seed,
  input  logic [31:0] stat_total_move_count,
  input  logic [15:0] stat_max_move_count,
  input  logic [31:0] stat_total_trial_count
);

  localparam logic [31:0] C_TRIALS       = TRIALS;
  localparam logic [31:0] C_TIMEOUT_LAST = TIMEOUT - 1;
  localparam logic [31:0] C_CLEAR_LAST   = STAT_RST_CYCLES - 1;
  localparam logic [7:0]  C_SEED_SUBST   = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [79:0] r_board;
  logic [7:0]  r_seed;
  logic [1:0]  r_dir;
  logic [31:0] r_cnt;
  logic [31:0] r_score;
  logic [15:0] r_max;
  logic [1:0]  r_best_dir;
  logic [31:0] r_best_score;
  logic [15:0] r_best_max;
  logic [3:0]  r_timeout_mask;

  logic        w_trial_hit;
  logic        w_timeout_hit;
  logic        w_better;
  logic        w_clear_end;
  logic [7:0]  w_seed_mix;

  // The trial budget is checked before the timeout so a simultaneous hit
  // counts as a real result, not a timeout.
  assign w_trial_hit   = (stat_total_trial_count >= C_TRIALS);
  assign w_timeout_hit = (r_cnt == C_TIMEOUT_LAST);
  assign w_clear_end   = (r_cnt == C_CLEAR_LAST);
  // Strictly greater keeps the lower direction on ties; direction 0 always loads.
  assign w_better      = (r_dir == 2'd0) || (r_score > r_best_score);
  assign w_seed_mix    = r_seed ^ {6'b0, r_dir};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    stat_rst = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        busy = 1'b1;
        if (w_clear_end) w_next = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        stat_rst = 1'b0;
        if (w_trial_hit || w_timeout_hit) w_next = S_CMP;
      end
      S_CMP: begin
        busy   = 1'b1;
        w_next = (r_dir == 2'd3) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latched inputs, cycle counter, per-direction score and best result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_board        <= '0;
      r_seed         <= '0;
      r_dir          <= '0;
      r_cnt          <= '0;
      r_score        <= '0;
      r_max          <= '0;
      r_best_dir     <= '0;
      r_best_score   <= '0;
      r_best_max     <= '0;
      r_timeout_mask <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_board        <= board_in;
            r_seed         <= seed_in;
            r_dir          <= 2'd0;
            r_cnt          <= '0;
            r_timeout_mask <= '0;
          end
        end
        S_CLEAR: begin
          r_cnt <= w_clear_end ? 32'd0 : r_cnt + 32'd1;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_trial_hit) begin
            r_score <= stat_total_move_count;
            r_max   <= stat_max_move_count;
          end else if (w_timeout_hit) begin
            r_score               <= '0;
            r_max                 <= '0;
            r_timeout_mask[r_dir] <= 1'b1;
          end
        end
        S_CMP: begin
          if (w_better) begin
            r_best_dir   <= r_dir;
            r_best_score <= r_score;
            r_best_max   <= r_max;
          end
          if (r_dir != 2'd3) begin
            r_dir <= r_dir + 2'd1;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign best_dir           = r_best_dir;
  assign best_score         = r_best_score;
  assign best_max           = r_best_max;
  assign timeout_mask       = r_timeout_mask;
  assign stat_restrected    = r_dir;
  assign stat_restrect_prob = prob_in;
  assign stat_board         = r_board;
  // A zero seed would lock up the engine's generator, so it is substituted.
  assign stat_seed          = (w_seed_mix == 8'd0) ? C_SEED_SUBST : w_seed_mix;

endmodule
`default_nettype wire

// File: tb/tb_mc_move_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_move_selector
// Brief    : Scoreboard bench for mc_move_selector with a stub statistics
//            engine (trial count advances every 4 RUN cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_move_selector;

  localparam int unsigned TRIALS          = 8;
  localparam int unsigned TIMEOUT         = 64;
  localparam int unsigned STAT_RST_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] board_in;
  logic [7:0]  seed_in;
  logic [2:0]  prob_in;
  logic        busy, done;
  logic [1:0]  best_dir;
  logic [31:0] best_score;
  logic [15:0] best_max;
  logic [3:0]  timeout_mask;
  logic        stat_rst;
  logic [1:0]  stat_restrected;
  logic [2:0]  stat_restrect_prob;
  logic [79:0] stat_board;
  logic [7:0]  stat_seed;
  logic [31:0] stat_total_move_count;
  logic [15:0] stat_max_move_count;
  logic [31:0] stat_total_trial_count;

  mc_move_selector #(
    .TRIALS(TRIALS), .TIMEOUT(TIMEOUT), .STAT_RST_CYCLES(STAT_RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in), .seed_in(seed_in),
    .prob_in(prob_in), .busy(busy), .done(done), .best_dir(best_dir),
    .best_score(best_score), .best_max(best_max), .timeout_mask(timeout_mask),
    .stat_rst(stat_rst), .stat_restrected(stat_restrected),
    .stat_restrect_prob(stat_restrect_prob), .stat_board(stat_board),
    .stat_seed(stat_seed), .stat_total_move_count(stat_total_move_count),
    .stat_max_move_count(stat_max_move_count),
    .stat_total_trial_count(stat_total_trial_count)
  );

  always #5 clk = ~clk;

  // Stub engine configuration, per direction.
  logic [31:0] tot   [4];
  logic [15:0] mx    [4];
  logic        stall [4];
  logic [31:0] eng_cyc;
  int          cyc = 0;

  // Stub engine cycle counter, held at zero while in reset.
  always @(posedge clk) begin
    if (stat_rst) eng_cyc <= '0;
    else          eng_cyc <= eng_cyc + 32'd1;
    cyc <= cyc + 1;
  end

  assign stat_total_trial_count = stall[stat_restrected] ? 32'd0 : (eng_cyc >> 2);
  assign stat_total_move_count  = tot[stat_restrected];
  assign stat_max_move_count    = mx[stat_restrected];

  typedef struct {
    logic [1:0]  d;
    logic [31:0] s;
    logic [15:0] m;
    logic [3:0]  tm;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  cur_seed;
  logic [79:0] cur_board;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_seed(input logic [7:0] s, input logic [1:0] d);
    logic [7:0] x;
    x = s ^ {6'b0, d};
    return (x == 8'd0) ? 8'h5A : x;
  endfunction

  // Monitor: pops the scoreboard on every done pulse and checks per-direction setup.
  logic prev_busy = 1'b0, prev_srst = 1'b1;
  logic [1:0] prev_dir = 2'd0;
  int start_cyc = 0, clr_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && !prev_busy) start_cyc = cyc;
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got done=1 expected no pulse");
      end else begin
        e = sb.pop_front();
        chk("best_dir", best_dir, e.d);
        chk("best_score", best_score, e.s);
        chk("best_max", best_max, e.m);
        chk("timeout_mask", timeout_mask, e.tm);
        chk("latency", cyc - start_cyc, e.lat);
      end
    end
    if (busy && stat_rst) begin
      if (!prev_busy || stat_restrected != prev_dir) clr_run = 1;
      else clr_run++;
    end
    if (busy && !stat_rst && prev_srst) begin
      chk("clear_len", clr_run, STAT_RST_CYCLES);
      chk("stat_seed", stat_seed, exp_seed(cur_seed, stat_restrected));
      chk("stat_board", stat_board == cur_board, 1'b1);
    end
    prev_busy = busy;
    prev_dir  = stat_restrected;
    prev_srst = stat_rst;
  end

  task automatic setup(input logic [31:0] t0, t1, t2, t3, input logic [15:0] m0, m1, m2, m3,
                       input logic [3:0] st, input logic [7:0] seed, input logic [79:0] brd);
    tot[0] = t0; tot[1] = t1; tot[2] = t2; tot[3] = t3;
    mx[0] = m0; mx[1] = m1; mx[2] = m2; mx[3] = m3;
    for (int i = 0; i < 4; i++) stall[i] = st[i];
    cur_seed = seed; cur_board = brd; seed_in = seed; board_in = brd;
  endtask

  task automatic push(input logic [1:0] d, input logic [31:0] s, input logic [15:0] m,
                      input logic [3:0] tm, input int lat);
    exp_t e;
    e.d = d; e.s = s; e.m = m; e.tm = tm; e.lat = lat;
    sb.push_back(e);
  endtask

  // Raise start until the DUT goes busy, then drop it.
  task automatic pulse_start();
    int n;
    n = 0;
    start = 1'b1;
    @(negedge clk);
    while (!busy && n < 10) begin @(negedge clk); n++; end
    start = 1'b0;
    chk("start_accepted", busy, 1'b1);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_best_dir"}, best_dir, 2'd0);
    chk({tag, "_best_score"}, best_score, 32'd0);
    chk({tag, "_best_max"}, best_max, 16'd0);
    chk({tag, "_timeout_mask"}, timeout_mask, 4'd0);
    chk({tag, "_stat_rst"}, stat_rst, 1'b1);
    chk({tag, "_stat_restrected"}, stat_restrected, 2'd0);
    chk({tag, "_stat_board_zero"}, stat_board == 80'd0, 1'b1);
    chk({tag, "_stat_seed"}, stat_seed, 8'h5A);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; prob_in = 3'd5;
    setup(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 8'h00, 80'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    chk("prob_pass", stat_restrect_prob, 3'd5);
    rst = 1'b0;
    @(negedge clk);

    // Basic sweep: best is direction 1; seed 02 gives 02,03,5A,01.
    setup(100, 300, 200, 50, 11, 33, 22, 5, 4'b0000, 8'h02, {16{5'd3}});
    push(2'd1, 32'd300, 16'd33, 4'b0000, 144);
    pulse_start();
    wait_empty();

    // Tie between 0, 1 and 3 keeps the lowest direction.
    setup(500, 500, 400, 500, 7, 8, 9, 10, 4'b0000, 8'hFF, {8{10'h2A5}});
    push(2'd0, 32'd500, 16'd7, 4'b0000, 144);
    pulse_start();
    wait_empty();

    // Direction 2 stalls and times out after 64 RUN cycles; its total is ignored.
    setup(10, 20, 999, 5, 1, 2, 3, 4, 4'b0100, 8'h03, {16{5'd11}});
    push(2'd1, 32'd20, 16'd2, 4'b0100, 3 * 36 + 67);
    pulse_start();
    wait_empty();

    // Reset in the middle of direction 1 RUN returns everything to reset values.
    setup(1, 32'h8000_0001, 3, 32'h7FFF_FFFF, 41, 42, 43, 44, 4'b0000, 8'h5C, {16{5'd1}});
    pulse_start();
    n = 0;
    while (!(stat_restrected == 2'd1 && !stat_rst) && n < 500) begin @(negedge clk); n++; end
    chk("reach_dir1_run", (stat_restrected == 2'd1) && !stat_rst, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;
    sb.delete();
    @(negedge clk);

    // Full sweep after reset; unsigned compare picks 0x80000001.
    push(2'd1, 32'h8000_0001, 16'd42, 4'b0000, 144);
    pulse_start();
    wait_empty();

    // start held high: one done per accepted start, restart from IDLE after DONE.
    setup(5, 9, 9, 3, 50, 51, 52, 53, 4'b0000, 8'h80, {16{5'd7}});
    push(2'd1, 32'd9, 16'd51, 4'b0000, 144);
    push(2'd1, 32'd9, 16'd51, 4'b0000, 144);
    start = 1'b1;
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    chk("held_first_done", done, 1'b1);
    @(negedge clk);
    chk("held_idle_busy", busy, 1'b0);
    chk("held_idle_done", done, 1'b0);
    @(negedge clk);
    chk("held_restart_busy", busy, 1'b1);
    start = 1'b0;
    wait_empty();
    repeat (5) @(negedge clk);
    chk("held_no_third", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
